// File: rtl/wt_write_buffer.sv
// Posted-write FIFO between the write-through data cache and main memory; also carries block
// fills, draining queued writes to the fill block first. Define WT_WBUF_COALESCE_EN for tail coalescing.
module wt_write_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 10,
  parameter int DW    = 32,
  parameter int BW    = 128
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_valid,
  output logic                   wr_ready,
  input  logic [AW-1:0]          wr_addr,
  input  logic [DW-1:0]          wr_data,
  input  logic                   rd_req,
  input  logic [AW-1:0]          rd_addr,
  output logic                   rd_valid,
  output logic [BW-1:0]          rd_data,
  output logic                   mem_req,
  output logic                   mem_we,
  output logic [AW-1:0]          mem_addr,
  output logic [DW-1:0]          mem_wdata,
  input  logic                   mem_ack,
  input  logic [BW-1:0]          mem_rdata,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count
);
  localparam int PW = $clog2(DEPTH);
  localparam int EW = AW - 2;

  typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;
  state_t state_reg, state_next;

  logic [EW-1:0]    addr_mem_reg [DEPTH];
  logic [DW-1:0]    data_mem_reg [DEPTH];
  logic [PW-1:0]    head_reg, tail_reg;
  logic [PW:0]      count_reg;
  logic             mem_req_reg, mem_we_reg;
  logic [AW-1:0]    mem_addr_reg;
  logic [DW-1:0]    mem_wdata_reg;
  logic [BW-1:0]    rd_data_reg;
  logic             fill_done_reg, rd_valid_reg;
  logic [DEPTH-1:0] entry_match;
  logic             rd_match, rd_pending, coal_hit, push, pop, empty_w, full_w;
  logic             unused_bits;

  assign empty_w = (count_reg == '0);
  // DEPTH is a power of two, so the count MSB alone marks full.
  assign full_w  = count_reg[PW];

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
      logic [PW-1:0] offset;
      assign offset = PW'(gi) - head_reg;
      assign entry_match[gi] = ({1'b0, offset} < count_reg) &&
                               (addr_mem_reg[gi][EW-1:2] == rd_addr[AW-1:4]);
    end
  endgenerate

  assign rd_match = |entry_match;
  // A fill just completed: ignore the still-held rd_req until the requester sees rd_valid.
  assign rd_pending = rd_req && !fill_done_reg && !rd_valid_reg;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (rd_pending && rd_match)  state_next = WRITE;
        else if (rd_pending)         state_next = READ;
        else if (!empty_w)           state_next = WRITE;
      end
      WRITE, READ: if (mem_ack) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

`ifdef WT_WBUF_COALESCE_EN
  logic [PW-1:0] last_idx;
  logic          head_busy;
  assign last_idx  = tail_reg - PW'(1);
  // The head's data is latched into mem_wdata on entry to WRITE, so it must not change then or later.
  assign head_busy = (last_idx == head_reg) && ((state_reg == WRITE) || (state_next == WRITE));
  assign coal_hit  = !empty_w && !head_busy && (addr_mem_reg[last_idx] == wr_addr[AW-1:2]);
`else
  assign coal_hit  = 1'b0;
`endif

  assign wr_ready = !full_w || coal_hit;
  assign push     = wr_valid && wr_ready && !coal_hit;
  assign pop      = (state_reg == WRITE) && mem_ack;

  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem_reg[tail_reg] <= wr_addr[AW-1:2];
      data_mem_reg[tail_reg] <= wr_data;
    end
`ifdef WT_WBUF_COALESCE_EN
    else if (wr_valid && wr_ready) begin
      data_mem_reg[last_idx] <= wr_data;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      head_reg      <= '0;
      tail_reg      <= '0;
      count_reg     <= '0;
      mem_req_reg   <= 1'b0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      rd_data_reg   <= '0;
      fill_done_reg <= 1'b0;
      rd_valid_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (push) tail_reg <= tail_reg + PW'(1);
      if (pop)  head_reg <= head_reg + PW'(1);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + (PW+1)'(1);
        2'b01:   count_reg <= count_reg - (PW+1)'(1);
        default: count_reg <= count_reg;
      endcase

      fill_done_reg <= (state_reg == READ) && mem_ack;
      rd_valid_reg  <= fill_done_reg;
      if ((state_reg == READ) && mem_ack) rd_data_reg <= mem_rdata;

      if ((state_reg == IDLE) && (state_next == WRITE)) begin
        mem_req_reg   <= 1'b1;
        mem_we_reg    <= 1'b1;
        mem_addr_reg  <= {addr_mem_reg[head_reg], 2'b00};
        mem_wdata_reg <= data_mem_reg[head_reg];
      end else if ((state_reg == IDLE) && (state_next == READ)) begin
        mem_req_reg  <= 1'b1;
        mem_we_reg   <= 1'b0;
        mem_addr_reg <= {rd_addr[AW-1:4], 4'b0000};
      end else if ((state_reg != IDLE) && mem_ack) begin
        mem_req_reg <= 1'b0;
      end
    end
  end

  assign mem_req     = mem_req_reg;
  assign mem_we      = mem_we_reg;
  assign mem_addr    = mem_addr_reg;
  assign mem_wdata   = mem_wdata_reg;
  assign rd_valid    = rd_valid_reg;
  assign rd_data     = rd_data_reg;
  assign empty       = empty_w;
  assign full        = full_w;
  assign count       = count_reg;
  assign unused_bits = ^{wr_addr[1:0], rd_addr[3:0]};

endmodule

// File: tb/tb_wt_write_buffer.sv
// Directed bench for wt_write_buffer: a memory responder checks every request against a scoreboard queue.
module tb_wt_write_buffer;
  logic         clk = 1'b0;
  logic         reset;
  logic         wr_valid, wr_ready;
  logic [9:0]   wr_addr;
  logic [31:0]  wr_data;
  logic         rd_req;
  logic [9:0]   rd_addr;
  logic         rd_valid;
  logic [127:0] rd_data;
  logic         mem_req, mem_we, mem_ack;
  logic [9:0]   mem_addr;
  logic [31:0]  mem_wdata;
  logic [127:0] mem_rdata;
  logic         empty, full;
  logic [2:0]   count;

  typedef struct packed {
    logic        we;
    logic [9:0]  addr;
    logic [31:0] wdata;
  } txn_t;

  txn_t         exp_q[$];
  logic [127:0] rdexp_q[$];
  logic [127:0] rd_block;
  int           n_checks = 0, n_pass = 0, n_fail = 0;
  int           ack_lat = 2;
  bit           ack_en = 1'b1;

  wt_write_buffer dut (
    .clk(clk), .reset(reset),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_data(rd_data),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .empty(empty), .full(full), .count(count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic exp_wr(input logic [9:0] a, input logic [31:0] d);
    txn_t t;
    t.we = 1'b1; t.addr = a; t.wdata = d;
    exp_q.push_back(t);
  endtask

  task automatic exp_rd(input logic [9:0] a, input logic [127:0] blk);
    txn_t t;
    t.we = 1'b0; t.addr = a; t.wdata = '0;
    exp_q.push_back(t);
    rdexp_q.push_back(blk);
  endtask

  // Offers one write and returns at the negedge after it is accepted; wr_valid stays high.
  task automatic do_write(input logic [9:0] a, input logic [31:0] d);
    int n = 0;
    wr_valid = 1'b1; wr_addr = a; wr_data = d;
    #1;
    while (!wr_ready && n < 50) begin @(negedge clk); #1; n++; end
    check("wr_accept_timeout", 128'(n < 50), 128'(1));
    @(negedge clk);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((!empty || mem_req) && n < budget) begin @(negedge clk); n++; end
    check("drain_timeout", 128'(n < budget), 128'(1));
  endtask

  task automatic wait_rd(output int n);
    logic [127:0] e;
    n = 0;
    do begin @(negedge clk); n++; end while (!rd_valid && n < 100);
    check("rd_timeout", 128'(rd_valid), 128'(1));
    if (rd_valid && rdexp_q.size() > 0) begin
      e = rdexp_q.pop_front();
      check("rd_data", rd_data, e);
      $display("fill  addr=%h data=%h", rd_addr, rd_data);
    end
    rd_req = 1'b0;
  endtask

  // Memory responder: acks after ack_lat cycles of mem_req and checks each request against exp_q.
  initial begin
    int   req_cycles = 0;
    txn_t held, e;
    mem_ack = 1'b0; mem_rdata = '0;
    forever begin
      @(negedge clk);
      mem_ack = 1'b0;
      if (reset || !mem_req) req_cycles = 0;
      else begin
        req_cycles++;
        if (req_cycles == 1) held = {mem_we, mem_addr, mem_wdata};
        if (ack_en && req_cycles >= ack_lat) begin
          if (req_cycles > 1) check("mem_hold", {mem_we, mem_addr, mem_wdata}, held);
          check("exp_q_nonempty", 128'(exp_q.size() > 0), 128'(1));
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (e.we) check("mem_write", {mem_we, mem_addr, mem_wdata}, e);
            else      check("mem_read", {mem_we, mem_addr}, {e.we, e.addr});
          end
          $display("mem   we=%0d addr=%h wdata=%h", mem_we, mem_addr, mem_wdata);
          mem_rdata = mem_we ? {$urandom, $urandom, $urandom, $urandom} : rd_block;
          mem_ack = 1'b1;
          req_cycles = 0;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    bit seen;
    reset = 1'b1; wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
    rd_req = 1'b0; rd_addr = '0; rd_block = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Reset values
    check("rst_mem_req", 128'(mem_req), 128'(0));
    check("rst_mem_we", 128'(mem_we), 128'(0));
    check("rst_mem_addr", 128'(mem_addr), 128'(0));
    check("rst_mem_wdata", 128'(mem_wdata), 128'(0));
    check("rst_rd_valid", 128'(rd_valid), 128'(0));
    check("rst_rd_data", rd_data, 128'(0));
    check("rst_count", 128'(count), 128'(0));
    check("rst_empty", 128'(empty), 128'(1));
    check("rst_full", 128'(full), 128'(0));
    check("rst_wr_ready", 128'(wr_ready), 128'(1));

    // Single write, ack 3 cycles after request rises
    ack_lat = 3; ack_en = 1'b1;
    exp_wr(10'h040, 32'hDEADBEEF);
    do_write(10'h040, 32'hDEADBEEF);
    wr_valid = 1'b0;
    check("w1_count_after_push", 128'(count), 128'(1));
    check("w1_req_idle_cycle", 128'(mem_req), 128'(0));
    @(negedge clk);
    check("w1_mem_req", 128'(mem_req), 128'(1));
    check("w1_mem_we", 128'(mem_we), 128'(1));
    check("w1_mem_addr", 128'(mem_addr), 128'(10'h040));
    check("w1_mem_wdata", 128'(mem_wdata), 128'(32'hDEADBEEF));
    repeat (2) @(negedge clk);
    check("w1_count_before_ack", 128'(count), 128'(1));
    @(negedge clk);
    check("w1_count_after_ack", 128'(count), 128'(0));
    check("w1_empty", 128'(empty), 128'(1));

    // Fill to full, reject a fifth write, then drain in order
    ack_en = 1'b0; ack_lat = 1;
    for (int i = 0; i < 4; i++) begin
      exp_wr(10'h100 + 10'(4 * i), 32'hA000_0000 + 32'(i));
      do_write(10'h100 + 10'(4 * i), 32'hA000_0000 + 32'(i));
    end
    wr_addr = 10'h110; wr_data = 32'h5555_5555;
    #1;
    check("full_flag", 128'(full), 128'(1));
    check("full_wr_ready", 128'(wr_ready), 128'(0));
    check("full_count", 128'(count), 128'(4));
    repeat (3) @(negedge clk);
    wr_valid = 1'b0;
    check("full_reject_count", 128'(count), 128'(4));
    ack_en = 1'b1;
    wait_idle(200);
    check("full_drained_all", 128'(exp_q.size()), 128'(0));
    check("full_empty_after", 128'(empty), 128'(1));

    // Read after write to the same block: matching write drains first, other write after
    ack_en = 1'b0; ack_lat = 2;
    rd_block = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
    exp_wr(10'h014, 32'h0000_0014);
    exp_rd(10'h010, rd_block);
    exp_wr(10'h200, 32'h0000_0200);
    do_write(10'h014, 32'h0000_0014);
    do_write(10'h200, 32'h0000_0200);
    wr_valid = 1'b0;
    rd_req = 1'b1; rd_addr = 10'h010;
    ack_en = 1'b1;
    wait_rd(lat);
    wait_idle(200);
    check("raw1_all_issued", 128'(exp_q.size()), 128'(0));

    // A matching write behind a non-matching head is also drained before the fill
    ack_en = 1'b0;
    rd_block = 128'hCAFE_0001_CAFE_0002_CAFE_0003_CAFE_0004;
    exp_wr(10'h300, 32'h0000_0300);
    exp_wr(10'h01C, 32'h0000_001C);
    exp_rd(10'h010, rd_block);
    exp_wr(10'h204, 32'h0000_0204);
    do_write(10'h300, 32'h0000_0300);
    do_write(10'h01C, 32'h0000_001C);
    do_write(10'h204, 32'h0000_0204);
    wr_valid = 1'b0;
    rd_req = 1'b1; rd_addr = 10'h018;
    ack_en = 1'b1;
    wait_rd(lat);
    wait_idle(200);
    check("raw2_all_issued", 128'(exp_q.size()), 128'(0));

    // Fill from an empty buffer: latency is memory latency (2) + 2
    ack_lat = 2;
    rd_block = 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF;
    exp_rd(10'h3F0, rd_block);
    rd_req = 1'b1; rd_addr = 10'h3F0;
    wait_rd(lat);
    check("rd_latency", 128'(lat), 128'(4));
    @(negedge clk);
    check("rd_valid_pulse", 128'(rd_valid), 128'(0));
    check("rd_data_hold", rd_data, 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF);
    check("rd_no_reissue", 128'(mem_req), 128'(0));

    // Reset while a write is outstanding with three entries queued
    ack_en = 1'b0;
    do_write(10'h080, 32'h0000_0080);
    do_write(10'h084, 32'h0000_0084);
    do_write(10'h088, 32'h0000_0088);
    wr_valid = 1'b0;
    check("mid_count", 128'(count), 128'(3));
    check("mid_mem_req", 128'(mem_req), 128'(1));
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid_rst_mem_req", 128'(mem_req), 128'(0));
    check("mid_rst_count", 128'(count), 128'(0));
    ack_en = 1'b1;
    seen = 1'b0;
    repeat (10) begin @(negedge clk); if (mem_req) seen = 1'b1; end
    check("mid_rst_no_requests", 128'(seen), 128'(0));

    // Back-to-back writes to one word while the head is busy
    ack_en = 1'b0; ack_lat = 2;
    exp_wr(10'h300, 32'h0000_0BAD);
`ifdef WT_WBUF_COALESCE_EN
    exp_wr(10'h08C, 32'h0000_0002);
`else
    exp_wr(10'h08C, 32'h0000_0001);
    exp_wr(10'h08C, 32'h0000_0002);
`endif
    do_write(10'h300, 32'h0000_0BAD);
    do_write(10'h08C, 32'h0000_0001);
    check("coal_count_first", 128'(count), 128'(2));
    do_write(10'h08C, 32'h0000_0002);
    wr_valid = 1'b0;
`ifdef WT_WBUF_COALESCE_EN
    check("coal_count_second", 128'(count), 128'(2));
`else
    check("coal_count_second", 128'(count), 128'(3));
`endif
    ack_en = 1'b1;
    wait_idle(200);
    check("coal_all_issued", 128'(exp_q.size()), 128'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
